// File: rtl/mips_data_bus_bridge.sv
// Bridge from the CPU data port to a wait-stated bus: registers each load/store,
// stalls the CPU through clk_enable until the access completes, and flags errors.
module mips_data_bus_bridge #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_READDATA   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] cpu_data_address_i,
    input  logic        cpu_data_write_i,
    input  logic        cpu_data_read_i,
    input  logic [31:0] cpu_data_writedata_i,
    output logic [31:0] cpu_data_readdata_o,
    output logic        cpu_clk_enable_o,
    output logic [31:0] mem_address_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_writedata_o,
    input  logic        mem_waitrequest_i,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_readdatavalid_i,
    output logic        bus_error_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            is_rd_q, is_rd_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cpu_req;
    logic            last_cycle;

    assign cpu_req    = cpu_data_read_i | cpu_data_write_i;
    // Counter holds the number of busy cycles already spent; this is the final allowed one.
    assign last_cycle = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        is_rd_d          = is_rd_q;
        err_d            = err_q;
        cnt_d            = cnt_q;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        cpu_clk_enable_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_clk_enable_o = !cpu_req;
                if (cpu_req) begin
                    addr_d  = cpu_data_address_i;
                    wdata_d = cpu_data_writedata_i;
                    is_rd_d = cpu_data_read_i;
                    cnt_d   = '0;
                    if (cpu_data_address_i[1:0] != 2'b00 || (cpu_data_read_i && cpu_data_write_i)) begin
                        err_d   = 1'b1;
                        rdata_d = ERR_READDATA;
                        state_d = DONE;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            CMD: begin
                mem_read_o  = is_rd_q;
                mem_write_o = !is_rd_q;
                cnt_d       = cnt_q + CW'(1);
                if (!mem_waitrequest_i) begin
                    if (!is_rd_q) begin
                        state_d = DONE;
                    end else if (mem_readdatavalid_i) begin
                        rdata_d = mem_readdata_i;
                        state_d = DONE;
                    end else begin
                        state_d = RDWAIT;
                    end
                end else if (last_cycle) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_READDATA;
                    state_d = DONE;
                end
            end
            RDWAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_readdatavalid_i) begin
                    rdata_d = mem_readdata_i;
                    state_d = DONE;
                end else if (last_cycle) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_READDATA;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The request still visible here is the one just completed.
                cpu_clk_enable_o = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_rd_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_rd_q <= is_rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_address_o       = addr_q;
    assign mem_writedata_o     = wdata_q;
    assign cpu_data_readdata_o = rdata_q;
    assign bus_error_o         = err_q;

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Bench for mips_data_bus_bridge: directed vector table, hand-written reset/timeout
// sequences, then random transactions against a transaction-level reference model.
module tb_mips_data_bus_bridge;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_wr, clk_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, wait_req, rdv, bus_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] bus_mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] m_rdata;
    logic        m_err;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, data;
        int          w, d, stall, cmd;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    mips_data_bus_bridge #(.TIMEOUT_CYCLES(T), .ERR_READDATA(ERR)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_data_address_i(cpu_addr), .cpu_data_write_i(cpu_wr),
        .cpu_data_read_i(cpu_rd), .cpu_data_writedata_i(cpu_wdata),
        .cpu_data_readdata_o(cpu_rdata), .cpu_clk_enable_o(clk_en),
        .mem_address_o(mem_addr), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_writedata_o(mem_wdata), .mem_waitrequest_i(wait_req),
        .mem_readdata_i(mem_rdata), .mem_readdatavalid_i(rdv),
        .bus_error_o(bus_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: outcome from address legality, wait/latency totals and timeout.
    task automatic model(inout vec_t v);
        int busy;
        if ((v.rd && v.wr) || v.addr[1:0] != 2'b00) begin
            m_err = 1'b1; m_rdata = ERR; v.stall = 1; v.cmd = 0;
        end else begin
            busy = v.wr ? v.w + 1 : v.w + 1 + v.d;
            if (busy > T) begin
                m_err = 1'b1; m_rdata = ERR;
                v.stall = 1 + T;
                v.cmd = (v.w + 1 < T) ? v.w + 1 : T;
            end else begin
                v.stall = 1 + busy;
                v.cmd = v.w + 1;
                if (v.wr) ref_mem[v.addr[5:2]] = v.data;
                else m_rdata = ref_mem[v.addr[5:2]];
            end
        end
        v.rdata = m_rdata;
        v.err = m_err;
    endtask

    // Drives one CPU request and plays the bus side: v.w wait cycles, then readdatavalid v.d cycles after accept.
    task automatic do_txn(input string nm, input vec_t v);
        int  stall = 0, cmd = 0, k = 0, p = 0;
        bit  acc = 0, done = 0;
        @(negedge clk);
        cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.data;
        wait_req = 1'b1; rdv = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (mem_read || mem_write) begin
                cmd++;
                chk({nm, "_cmd_dir"}, {30'd0, mem_read, mem_write}, {30'd0, v.rd, v.wr});
                chk({nm, "_cmd_addr"}, mem_addr, v.addr);
                if (v.wr) chk({nm, "_cmd_wdata"}, mem_wdata, v.data);
                wait_req = (k < v.w);
                rdv = 1'b0;
                if (k == v.w) begin
                    acc = 1;
                    if (v.wr) bus_mem[mem_addr[5:2]] = mem_wdata;
                    else rdv = (v.d == 0);
                end
                k++;
            end else begin
                wait_req = 1'($urandom);
                rdv = 1'b0;
                if (acc && v.rd) begin
                    p++;
                    rdv = (p == v.d);
                end
            end
            mem_rdata = rdv ? bus_mem[v.addr[5:2]] : $urandom;
            if (!clk_en) stall++;
            else begin
                done = 1;
                chk({nm, "_done_nocmd"}, {31'd0, mem_read | mem_write}, 32'd0);
                chk({nm, "_rdata"}, cpu_rdata, v.rdata);
                chk({nm, "_bus_error"}, {31'd0, bus_err}, {31'd0, v.err});
            end
        end
        if (!done) chk({nm, "_completion_bound"}, 32'd0, 32'd1);
        chk({nm, "_stall_cycles"}, stall, v.stall);
        chk({nm, "_cmd_cycles"}, cmd, v.cmd);
        rdv = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_rd = 1'b0; cpu_wr = 1'b0;
            rdv = 1'($urandom); mem_rdata = $urandom;
            #1;
            chk("idle_clk_en", {31'd0, clk_en}, 32'd1);
            chk("idle_nocmd", {31'd0, mem_read | mem_write}, 32'd0);
            chk("idle_rdata", cpu_rdata, m_rdata);
        end
        rdv = 1'b0;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            bus_mem[i] = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        bus_mem[8] = 32'hCAFE_F00D; ref_mem[8] = 32'hCAFE_F00D;
        m_rdata = '0; m_err = 1'b0;

        //          rd    wr    addr        data          w  d  stall cmd rdata          err
        tbl[0] = '{1'b0, 1'b1, 32'h10, 32'h1234_5678, 0, 0, 2, 1, 32'h0,          1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h20, 32'h0,         3, 2, 7, 4, 32'hCAFE_F00D,  1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h10, 32'h0,         0, 1, 3, 1, 32'h1234_5678,  1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h14, 32'hA5A5_0F0F, 1, 0, 3, 2, 32'h1234_5678,  1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h14, 32'h0,         0, 0, 2, 1, 32'hA5A5_0F0F,  1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h22, 32'h0,         0, 0, 1, 0, ERR,            1'b1};
        tbl[6] = '{1'b1, 1'b1, 32'h30, 32'h5555_AAAA, 0, 0, 1, 0, ERR,            1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h11, 32'h7777_7777, 0, 0, 1, 0, ERR,            1'b1};

        rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        wait_req = 1'b0; rdv = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_bus_error", {31'd0, bus_err}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table entries: each request follows its predecessor's DONE directly.
        for (int i = 0; i < 8; i++) begin
            v = tbl[i];
            model(v);
            do_txn($sformatf("tbl%0d", i), tbl[i]);
        end

        // Stuck waitrequest: timeout after T command cycles, then a normal access.
        v = '{1'b1, 1'b0, 32'h18, 32'h0, 1000, 0, 0, 0, 32'h0, 1'b0};
        model(v);
        chk("to_model_stall", v.stall, T + 1);
        do_txn("timeout", '{1'b1, 1'b0, 32'h18, 32'h0, 1000, 0, T + 1, T, ERR, 1'b1});
        v = '{1'b1, 1'b0, 32'h10, 32'h0, 0, 1, 0, 0, 32'h0, 1'b0};
        model(v);
        do_txn("after_timeout", '{1'b1, 1'b0, 32'h10, 32'h0, 0, 1, 3, 1, 32'h1234_5678, 1'b1});

        // Reset in the middle of RDWAIT, then a stale readdatavalid.
        @(negedge clk);
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h20; wait_req = 1'b0; rdv = 1'b0;
        @(negedge clk); #1;
        chk("rseq_cmd_read", {31'd0, mem_read}, 32'd1);
        @(negedge clk); #1;
        chk("rseq_rdwait_read_low", {31'd0, mem_read}, 32'd0);
        chk("rseq_rdwait_stall", {31'd0, clk_en}, 32'd0);
        rst_n = 1'b0; #1;
        chk("rseq_rst_mem_addr", mem_addr, 32'd0);
        chk("rseq_rst_rdata", cpu_rdata, 32'd0);
        chk("rseq_rst_err", {31'd0, bus_err}, 32'd0);
        chk("rseq_rst_cmd", {31'd0, mem_read | mem_write}, 32'd0);
        cpu_rd = 1'b0; #1;
        chk("rseq_rst_clk_en", {31'd0, clk_en}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1; rdv = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rdv = 1'b0; #1;
        chk("rseq_stale_rdata", cpu_rdata, 32'd0);
        chk("rseq_stale_clk_en", {31'd0, clk_en}, 32'd1);
        chk("rseq_stale_cmd", {31'd0, mem_read | mem_write}, 32'd0);
        m_err = 1'b0; m_rdata = '0;
        v = '{1'b1, 1'b0, 32'h10, 32'h0, 0, 1, 0, 0, 32'h0, 1'b0};
        model(v);
        do_txn("after_reset", v);

        for (int n = 0; n < 80; n++) begin
            int idx, kind;
            idx  = $urandom_range(15, 0);
            kind = $urandom_range(99, 0);
            v.rd   = 1'($urandom);
            v.wr   = !v.rd;
            v.addr = 32'(idx * 4);
            v.data = $urandom;
            v.w    = $urandom_range(3, 0);
            v.d    = $urandom_range(3, 0);
            if (kind < 5) v.addr = v.addr + 32'($urandom_range(3, 1));
            else if (kind < 8) begin v.rd = 1'b1; v.wr = 1'b1; end
            else if (kind < 12) v.w = 20;
            model(v);
            do_txn($sformatf("rnd%0d", n), v);
            if ($urandom_range(3, 0) == 0) idle_gap($urandom_range(2, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
